// File: rtl/output_buf_unpack.sv
// output_buf_unpack: read side of the output buffer. Fetches packed words
// through the buffer's synchronous read port, unpacks them element by
// element and streams them out over a valid/ready handshake.
// Optional feature: define UNPACK_MSB_FIRST_EN to emit the most significant
// element of each word first (left shift) instead of the least significant.

`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif

module output_buf_unpack #(
   parameter int DATA_W = `OUTPUT_BUF_DATASIZE,
   parameter int ELEM_W = 8,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = $clog2(DATA_W/ELEM_W)+1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_words,
   input  logic [CNT_W-1:0]  elems_per_word,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   output logic [ELEM_W-1:0] out_data,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   localparam int                NELEM   = DATA_W / ELEM_W;
   localparam logic [CNT_W-1:0]  MAX_EPW = CNT_W'(NELEM);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_TWO = CNT_W'(2);
   localparam logic [ADDR_W:0]   WRD_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

   typedef enum logic [2:0] {IDLE, READ, LOAD, EMIT, FIN} state_t;

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_next;
   logic [CNT_W-1:0]  cnt;        // elements still to emit from the current word
   logic [CNT_W-1:0]  epw;        // latched elements-per-word, already clamped
   logic [CNT_W-1:0]  epw_in;
   logic [ADDR_W:0]   words_rem;  // words not yet loaded into the shift register
   logic              handshake;

   assign handshake = out_valid && out_ready;

   // Map elements-per-word: 0 and out-of-range values both mean a full word.
   always_comb begin
      // NOTE: assign a default before any condition so no latch is inferred.
      epw_in = elems_per_word;
      if (elems_per_word == '0 || elems_per_word > MAX_EPW) epw_in = MAX_EPW;
   end

`ifdef UNPACK_MSB_FIRST_EN
   assign shreg_next = shreg << ELEM_W;
   assign out_data   = shreg[DATA_W-1 -: ELEM_W];
`else
   assign shreg_next = shreg >> ELEM_W;
   assign out_data   = shreg[ELEM_W-1:0];
`endif

   // Job sequencer: one read, one load, then emit the word's elements.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         epw       <= '0;
         words_rem <= '0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so every register samples pre-edge values.
         rd_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  epw       <= epw_in;
                  words_rem <= num_words;
                  rd_addr   <= base_addr;
                  if (num_words != '0) begin
                     state <= READ;
                     rd_en <= 1'b1;
                     busy  <= 1'b1;
                  end else begin
                     state <= FIN;
                  end
               end
            end
            READ: begin
               // rd_en is high during this state; data returns next cycle.
               state <= LOAD;
            end
            LOAD: begin
               shreg     <= rd_data;
               cnt       <= epw;
               words_rem <= words_rem - WRD_ONE;
               out_valid <= 1'b1;
               out_last  <= (words_rem == WRD_ONE) && (epw == CNT_ONE);
               state     <= EMIT;
            end
            EMIT: begin
               if (handshake) begin
                  shreg <= shreg_next;
                  cnt   <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     if (words_rem != '0) begin
                        state   <= READ;
                        rd_en   <= 1'b1;
                        rd_addr <= rd_addr + ADR_ONE;
                     end else begin
                        state <= FIN;
                     end
                  end else begin
                     out_last <= (words_rem == '0) && (cnt == CNT_TWO);
                  end
               end
            end
            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_output_buf_unpack.sv
// tb_output_buf_unpack: directed bench for output_buf_unpack. A table of
// jobs with hand-computed element streams, plus hand-written sequences for
// latency, backpressure, zero length, ignored start, and mid-job reset.
// Build with UNPACK_MSB_FIRST_EN defined to check the MSB-first variant.

module tb_output_buf_unpack;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  base_addr;
   logic [6:0]  num_words;
   logic [2:0]  elems_per_word;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        done;

   output_buf_unpack dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .num_words(num_words), .elems_per_word(elems_per_word),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Buffer model: synchronous read, data one cycle after rd_en.
   logic [31:0] mem [64];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      logic [5:0]  base;
      logic [6:0]  nw;
      logic [2:0]  epw;
      int          n;
      logic [63:0] elems;   // element i in bits [8*i +: 8]
   } vec_t;

   vec_t vecs [7];

   int vectors = 0;
   int miscompares = 0;

   // Monitor state, sampled on the falling edge.
   logic [7:0] got [$];
   logic       lasts [$];
   logic [5:0] rd_addrs [$];
   int first_rd, first_valid, first_busy, last_acc, done_cnt, done_cyc, busy_cnt;
   logic busy_at_done;

   always @(negedge clk) begin
      if (!rst) begin
         if (rd_en) rd_addrs.push_back(rd_addr);
         if (rd_en && first_rd < 0) first_rd = cyc;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (busy && first_busy < 0) first_busy = cyc;
         if (busy) busy_cnt++;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            lasts.push_back(out_last);
            last_acc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got.delete();
      lasts.delete();
      rd_addrs.delete();
      first_rd = -1; first_valid = -1; first_busy = -1; last_acc = -1;
      done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_at_done = 1'bx;
   endtask

   task automatic start_job(input logic [5:0] b, input logic [6:0] nw,
                            input logic [2:0] e, output int sc);
      start = 1'b1; base_addr = b; num_words = nw; elems_per_word = e;
      sc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done_cnt == 0 && k < 300) begin
         tick();
         k++;
      end
      check({tag, " done_seen"}, 64'(done_cnt != 0), 64'd1);
      tick();
      tick();
   endtask

   task automatic check_job(input string tag, input vec_t v);
      logic [63:0] lm;
      logic [7:0]  e;
      check({tag, " n_elem"}, 64'(got.size()), 64'(v.n));
      for (int i = 0; i < v.n; i++) begin
         e = (i < got.size()) ? got[i] : 8'hxx;
         check($sformatf("%s elem%0d", tag, i), 64'(e), 64'(v.elems[8*i +: 8]));
      end
      lm = '0;
      for (int i = 0; i < lasts.size() && i < 64; i++) lm[i] = lasts[i];
      check({tag, " last_mask"}, lm, 64'd1 << (v.n - 1));
      check({tag, " rd_count"}, 64'(rd_addrs.size()), 64'(v.nw));
      for (int i = 0; i < int'(v.nw) && i < rd_addrs.size(); i++)
         check($sformatf("%s rd_addr%0d", tag, i), 64'(rd_addrs[i]), 64'(6'(v.base + 6'(i))));
      check({tag, " done_count"}, 64'(done_cnt), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      int k;

      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0]  = 32'hDDCCBBAA;
      mem[4]  = 32'h44332211;
      mem[5]  = 32'h88776655;
      mem[63] = 32'h04030201;

`ifdef UNPACK_MSB_FIRST_EN
      vecs[0] = '{6'd4,  7'd2, 3'd4, 8, 64'h5566778811223344};
      vecs[1] = '{6'd0,  7'd1, 3'd2, 2, 64'h000000000000CCDD};
      vecs[2] = '{6'd0,  7'd1, 3'd0, 4, 64'h00000000AABBCCDD};
      vecs[3] = '{6'd63, 7'd2, 3'd4, 8, 64'hAABBCCDD01020304};
      vecs[4] = '{6'd0,  7'd1, 3'd7, 4, 64'h00000000AABBCCDD};
      vecs[5] = '{6'd4,  7'd2, 3'd1, 2, 64'h0000000000008844};
      vecs[6] = '{6'd0,  7'd1, 3'd3, 3, 64'h0000000000BBCCDD};
`else
      vecs[0] = '{6'd4,  7'd2, 3'd4, 8, 64'h8877665544332211};
      vecs[1] = '{6'd0,  7'd1, 3'd2, 2, 64'h000000000000BBAA};
      vecs[2] = '{6'd0,  7'd1, 3'd0, 4, 64'h00000000DDCCBBAA};
      vecs[3] = '{6'd63, 7'd2, 3'd4, 8, 64'hDDCCBBAA04030201};
      vecs[4] = '{6'd0,  7'd1, 3'd7, 4, 64'h00000000DDCCBBAA};
      vecs[5] = '{6'd4,  7'd2, 3'd1, 2, 64'h0000000000005511};
      vecs[6] = '{6'd0,  7'd1, 3'd3, 3, 64'h0000000000CCBBAA};
`endif

      rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
      elems_per_word = '0; out_ready = 1'b1;
      clear_mon();
      repeat (3) tick();
      check("reset_state", {57'd0, rd_en, out_valid, out_last, busy, done, rd_addr, out_data},
            64'd0);
      rst = 1'b0;
      tick();

      // Table of jobs; the first also carries the latency checks.
      for (int v = 0; v < 7; v++) begin
         clear_mon();
         start_job(vecs[v].base, vecs[v].nw, vecs[v].epw, sc);
         wait_done($sformatf("vec%0d", v));
         check_job($sformatf("vec%0d", v), vecs[v]);
         if (v == 0) begin
            check("lat_rd_en",     64'(first_rd - sc),     64'd1);
            check("lat_busy",      64'(first_busy - sc),   64'd1);
            check("lat_out_valid", 64'(first_valid - sc),  64'd3);
            check("lat_done",      64'(done_cyc - last_acc), 64'd2);
            check("busy_at_done",  64'(busy_at_done),      64'd0);
         end
      end

      // Backpressure on the second element.
      clear_mon();
      start_job(vecs[0].base, vecs[0].nw, vecs[0].epw, sc);
      k = 0;
      while (!(got.size() == 1 && out_valid) && k < 50) begin
         tick();
         k++;
      end
      check("bp_reached", 64'(got.size()), 64'd1);
      out_ready = 1'b0;
      repeat (3) begin
         tick();
         check("bp_hold", {54'd0, out_valid, out_last, rd_en, out_data},
               {54'd0, 1'b1, 1'b0, 1'b0, vecs[0].elems[15:8]});
      end
      out_ready = 1'b1;
      wait_done("bp");
      check_job("bp", vecs[0]);

      // Zero-length job: no reads, done two cycles after the start cycle.
      clear_mon();
      start_job(6'd9, 7'd0, 3'd4, sc);
      wait_done("zero");
      check("zero_rd_count", 64'(rd_addrs.size()), 64'd0);
      check("zero_done_lat", 64'(done_cyc - sc), 64'd2);
      check("zero_busy",     64'(busy_cnt), 64'd0);
      check("zero_no_elem",  64'(got.size()), 64'd0);

      // A start while busy must be ignored.
      clear_mon();
      start_job(vecs[0].base, vecs[0].nw, vecs[0].epw, sc);
      k = 0;
      while (got.size() < 3 && k < 50) begin
         tick();
         k++;
      end
      start_job(6'd0, 7'd1, 3'd4, sc);
      wait_done("ign");
      repeat (10) tick();
      check_job("ign", vecs[0]);

      // Asynchronous reset in the middle of EMIT, then a clean new job.
      clear_mon();
      start_job(vecs[0].base, vecs[0].nw, vecs[0].epw, sc);
      k = 0;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
      check("rst_mid_reached", 64'(out_valid), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_state", {57'd0, rd_en, out_valid, out_last, busy, done, rd_addr, out_data},
            64'd0);
      tick();
      rst = 1'b0;
      tick();
      clear_mon();
      start_job(vecs[1].base, vecs[1].nw, vecs[1].epw, sc);
      wait_done("post_rst");
      check_job("post_rst", vecs[1]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
